// File: rtl/ups_axi4l_regs_if.sv
// rtl/ups_axi4l_regs_if.sv - AXI4-Lite channel bundle for the ups register block
interface ups_axi4l_regs_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/ups_axi4l_regs.sv
// rtl/ups_axi4l_regs.sv - AXI4-Lite slave with fifteen control registers and an ID word
// Word-indexed map: 0..14 read/write, 15 read-only ID, anything with addr[31:4] set is SLVERR.
module ups_axi4l_regs #(
  parameter logic [31:0] ID_VALUE  = 32'h5550_5301,
  parameter bit          USE_WSTRB = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  ups_axi4l_regs_if.slave ca4l,
  output logic [479:0]    ctrl_q,
  output logic [14:0]     wr_pulse
);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [31:0] regs [15];

  logic        aw_held, w_held;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic        aw_hs, w_hs, commit, wr_ok;
  logic [3:0]  wr_idx;
  logic [31:0] wr_mask;

  assign aw_hs  = ca4l.awvalid && awready_q;
  assign w_hs   = ca4l.wvalid && wready_q;
  assign commit = aw_held && w_held;
  assign wr_idx = aw_addr_q[3:0];
  assign wr_ok  = (aw_addr_q[31:4] == 28'd0) && (wr_idx != 4'd15);

  always_comb begin
    wr_mask = '1;
    if (USE_WSTRB) begin
      for (int k = 0; k < 4; k++) wr_mask[8*k +: 8] = {8{w_strb_q[k]}};
    end
  end

  // AW and W are captured independently; the commit edge also clears both flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      wr_pulse  <= '0;
      for (int n = 0; n < 15; n++) regs[n] <= '0;
    end else begin
      awready_q <= ca4l.awvalid && !awready_q && !aw_held && !bvalid_q;
      wready_q  <= ca4l.wvalid && !wready_q && !w_held && !bvalid_q;
      wr_pulse  <= '0;
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= ca4l.awaddr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= ca4l.wdata;
        w_strb_q <= ca4l.wstrb;
      end
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        for (int n = 0; n < 15; n++) begin
          if (wr_ok && wr_idx == 4'(n)) begin
            regs[n]     <= (regs[n] & ~wr_mask) | (w_data_q & wr_mask);
            wr_pulse[n] <= 1'b1;
          end
        end
      end else if (bvalid_q && ca4l.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign ca4l.awready = awready_q;
  assign ca4l.wready  = wready_q;
  assign ca4l.bvalid  = bvalid_q;
  assign ca4l.bresp   = bresp_q;

  always_comb begin
    for (int n = 0; n < 15; n++) ctrl_q[32*n +: 32] = regs[n];
  end

  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  r_state_e    r_state, r_next;
  logic        arready_q, arready_d;
  logic [31:0] rdata_q, rdata_d, rd_val;
  logic [1:0]  rresp_q, rresp_d, rd_resp;
  logic [3:0]  rd_idx;

  assign rd_idx = ca4l.araddr[3:0];

  // Read mux sees the registers before any write landing on the same edge.
  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_SLVERR;
    if (ca4l.araddr[31:4] == 28'd0) begin
      rd_resp = RESP_OKAY;
      if (rd_idx == 4'd15) rd_val = ID_VALUE;
      for (int n = 0; n < 15; n++) begin
        if (rd_idx == 4'(n)) rd_val = regs[n];
      end
    end
  end

  always_comb begin
    r_next    = r_state;
    arready_d = 1'b0;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state)
      R_IDLE: begin
        arready_d = ca4l.arvalid && !arready_q;
        if (ca4l.arvalid && arready_q) begin
          r_next  = R_DATA;
          rdata_d = rd_val;
          rresp_d = rd_resp;
        end
      end
      R_DATA: begin
        if (ca4l.rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state   <= r_next;
      arready_q <= arready_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign ca4l.arready = arready_q;
  assign ca4l.rvalid  = (r_state == R_DATA);
  assign ca4l.rdata   = rdata_q;
  assign ca4l.rresp   = rresp_q;

  logic unused_prot;
  assign unused_prot = ^{ca4l.awprot, ca4l.arprot};
endmodule

// File: tb/tb_ups_axi4l_regs.sv
// tb/tb_ups_axi4l_regs.sv - scoreboard bench for ups_axi4l_regs
module tb_ups_axi4l_regs;
  localparam logic [31:0] ID        = 32'h5550_5301;
  localparam bit          USE_WSTRB = 1'b0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [479:0]  ctrl_q;
  logic [14:0]   wr_pulse;

  ups_axi4l_regs_if bus ();

  ups_axi4l_regs #(.ID_VALUE(ID), .USE_WSTRB(USE_WSTRB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ca4l     (bus),
    .ctrl_q   (ctrl_q),
    .wr_pulse (wr_pulse)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] resp; logic [14:0] pulse; } b_exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [31:0] model [15];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [479:0] model_packed();
    logic [479:0] p;
    for (int n = 0; n < 15; n++) p[32*n +: 32] = model[n];
    return p;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    b_exp_t e;
    if (addr < 32'd15) begin
      for (int k = 0; k < 4; k++)
        if (!USE_WSTRB || strb[k]) model[addr[3:0]][8*k +: 8] = data[8*k +: 8];
      e.resp  = 2'b00;
      e.pulse = 15'(1) << addr[3:0];
    end else begin
      e.resp  = 2'b10;
      e.pulse = '0;
    end
    bq.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, away from the edge the DUT uses.
  logic        pb_valid = 0, pb_ready = 0, pr_valid = 0, pr_ready = 0;
  logic [1:0]  pb_resp = 0, pr_resp = 0;
  logic [31:0] pr_data = 0;
  logic [14:0] exp_pulse;
  b_exp_t      be;
  r_exp_t      re;

  always @(negedge clk) begin
    exp_pulse = '0;
    if (rst_n) begin
      if (bus.bvalid && !pb_valid) begin
        if (bq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_bvalid: got bresp %0h expected no response", bus.bresp);
        end else begin
          be = bq.pop_front();
          chk("bresp", bus.bresp, be.resp);
          exp_pulse = be.pulse;
          chk("ctrl_q", ctrl_q, model_packed());
        end
      end
      if (bus.bvalid && pb_valid && !pb_ready) chk("bresp_stable", bus.bresp, pb_resp);
      if (bus.bvalid) begin
        chk("awready_while_bvalid", bus.awready, 0);
        chk("wready_while_bvalid", bus.wready, 0);
      end
      chk("wr_pulse", wr_pulse, exp_pulse);
      if (bus.rvalid && !pr_valid) begin
        if (rq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rvalid: got rdata %0h expected no response", bus.rdata);
        end else begin
          re = rq.pop_front();
          chk("rdata", bus.rdata, re.data);
          chk("rresp", bus.rresp, re.resp);
        end
      end
      if (bus.rvalid && pr_valid && !pr_ready) begin
        chk("rdata_stable", bus.rdata, pr_data);
        chk("rresp_stable", bus.rresp, pr_resp);
      end
      if (bus.rvalid) chk("arready_in_rdata", bus.arready, 0);
    end
    pb_valid = bus.bvalid; pb_ready = bus.bready; pb_resp = bus.bresp;
    pr_valid = bus.rvalid; pr_ready = bus.rready; pr_resp = bus.rresp; pr_data = bus.rdata;
  end

  // dly > 0 delays AWVALID, dly < 0 delays WVALID; hold keeps BREADY low that many cycles.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int dly, input int hold, input bit pre_aw);
    int aw_at, w_at, cyc, n;
    bit aw_done, w_done;
    aw_at = (dly > 0) ? dly : 0;
    w_at  = (dly < 0) ? -dly : 0;
    model_write(addr, data, strb);
    bus.bready = (hold == 0);
    bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
    bus.awprot = 3'($urandom());
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 100) begin
      bus.awvalid = !aw_done && (cyc >= aw_at);
      bus.wvalid  = !w_done && (cyc >= w_at);
      @(negedge clk);
      if (bus.awvalid && bus.awready) aw_done = 1;
      if (bus.wvalid && bus.wready) w_done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    bus.awvalid = 0; bus.wvalid = 0;
    if (!(aw_done && w_done)) begin
      total++; bad++;
      $display("FAIL write_handshake: addr %0h got no accept expected within 100 cycles", addr);
      bus.bready = 1;
      return;
    end
    n = 0;
    @(negedge clk);
    while (!bus.bvalid && n < 20) begin n++; @(negedge clk); end
    chk("write_latency", n, 1);
    @(posedge clk); #1;
    if (n >= 20) begin bus.bready = 1; return; end
    repeat (hold) begin
      if (pre_aw) begin bus.awaddr = 32'h5; bus.awvalid = 1; end
      @(posedge clk); #1;
    end
    bus.bready = 1;
    @(posedge clk); #1;
    bus.awvalid = 0;
    chk("bvalid_drop", bus.bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold);
    r_exp_t e;
    int cyc;
    bit done;
    if (addr < 32'd15) e.data = model[addr[3:0]];
    else if (addr == 32'd15) e.data = ID;
    else e.data = 32'd0;
    e.resp = (addr <= 32'd15) ? 2'b00 : 2'b10;
    rq.push_back(e);
    bus.rready = (hold == 0);
    bus.araddr = addr;
    bus.arprot = 3'($urandom());
    done = 0; cyc = 0;
    while (!done && cyc < 100) begin
      bus.arvalid = 1;
      @(negedge clk);
      if (bus.arready) done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    bus.arvalid = 0;
    if (!done) begin
      total++; bad++;
      $display("FAIL read_handshake: addr %0h got no accept expected within 100 cycles", addr);
      bus.rready = 1;
      return;
    end
    @(negedge clk);
    chk("read_latency_rvalid", bus.rvalid, 1);
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    bus.rready = 1;
    @(posedge clk); #1;
    chk("rvalid_drop", bus.rvalid, 0);
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 0;
    repeat (cycles) begin @(posedge clk); #1; end
    rst_n = 1;
    for (int n = 0; n < 15; n++) model[n] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end within 50000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    bit done;
    bus.awaddr = 0; bus.awprot = 0; bus.awvalid = 0;
    bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0; bus.bready = 1;
    bus.araddr = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 1;
    @(posedge clk); #1;
    apply_reset(3);

    chk("rst_awready", bus.awready, 0);
    chk("rst_wready", bus.wready, 0);
    chk("rst_bvalid", bus.bvalid, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_rvalid", bus.rvalid, 0);
    chk("rst_bresp", bus.bresp, 0);
    chk("rst_rresp", bus.rresp, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_ctrl_q", ctrl_q, 0);
    chk("rst_wr_pulse", wr_pulse, 0);

    do_write(32'h0, 32'h10, 4'hF, 0, 0, 0);
    do_read(32'h0, 0);
    do_write(32'h1, 32'h11, 4'h0, 0, 0, 0);
    do_write(32'h2, 32'h0000_C38D, 4'h0, 0, 0, 0);
    do_read(32'h1, 1);
    do_read(32'h2, 0);
    do_read(32'h0, 2);
    do_write(32'h3, 32'hA5A5_A5A5, 4'hF, 3, 0, 0);
    do_read(32'h3, 0);
    do_write(32'hF, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_write(32'h20, 32'h1234_5678, 4'hF, -2, 0, 0);
    do_read(32'hF, 0);
    do_read(32'h20, 0);
    do_write(32'h6, 32'h0000_600D, 4'hF, 0, 5, 1);
    do_write(32'h5, 32'h5555_5555, 4'hF, 0, 0, 0);
    do_read(32'h5, 0);
    do_read(32'h6, 0);

    bus.awaddr = 32'h4; bus.awvalid = 1; done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus.awready) done = 1;
      @(posedge clk); #1;
    end
    bus.awvalid = 0;
    chk("abort_aw_accepted", done, 1);
    apply_reset(1);
    repeat (6) begin @(posedge clk); #1; end
    chk("abort_no_update", ctrl_q, 0);
    chk("abort_no_bvalid", bus.bvalid, 0);
    do_write(32'h4, 32'hCAFE_0004, 4'hF, 1, 0, 0);
    do_read(32'h4, 0);

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 16) a = 32'(r);
      else begin
        a = $urandom();
        if (a[31:4] == 28'd0) a[4] = 1'b1;
      end
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom(), 4'($urandom()), int'($urandom_range(0, 6)) - 3,
                 int'($urandom_range(0, 2)), 0);
      else
        do_read(a, int'($urandom_range(0, 2)));
    end

    repeat (3) begin @(posedge clk); #1; end
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ups_axi4l_regs.md
UPS_AXI4L_REGS -- requirements
Module: ups_axi4l_regs

Interface
REQ-001 Parameter ID_VALUE, default 32'h5550_5301: read-only value returned at register index 15.
REQ-002 Parameter USE_WSTRB, default 0: 0 = full-word writes with WSTRB ignored; 1 = byte-lane writes per WSTRB.
REQ-003 clk  input  1  single clock, shared with the AXI4-Lite master (fclk).
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 ca4l_awaddr  input  32 / ca4l_awprot  input  3 / ca4l_awvalid  input  1 / ca4l_awready  output  1  write-address channel; AWPROT is ignored.
REQ-006 ca4l_wdata  input  32 / ca4l_wstrb  input  4 / ca4l_wvalid  input  1 / ca4l_wready  output  1  write-data channel.
REQ-007 ca4l_bresp  output  2 / ca4l_bvalid  output  1 / ca4l_bready  input  1  write-response channel.
REQ-008 ca4l_araddr  input  32 / ca4l_arprot  input  3 / ca4l_arvalid  input  1 / ca4l_arready  output  1  read-address channel; ARPROT is ignored.
REQ-009 ca4l_rdata  output  32 / ca4l_rresp  output  2 / ca4l_rvalid  output  1 / ca4l_rready  input  1  read-data channel.
REQ-010 ctrl_q  output  480  registers 0..14, concatenated; register n occupies bits [32n+31:32n].
REQ-011 wr_pulse  output  15  one-cycle strobe per register, asserted in the cycle after that register is updated.

Function
REQ-012 Addressing: register index = addr[3:0] (word index, not byte address); addr[31:4] != 0 is out of range.
REQ-013 Write path tracks two capture flags, aw_held and w_held, which are captured independently, so AW may arrive before, with, or after W.
REQ-014 AWREADY: registered; pulses high for exactly 1 cycle, in the cycle after AWVALID is sampled high with !aw_held and !bvalid; the address is captured on AWVALID&AWREADY.
REQ-015 WREADY: same rule as AWREADY, using WVALID and w_held; WDATA/WSTRB are captured on WVALID&WREADY.
REQ-016 When aw_held && w_held: the write commits in the next cycle, BVALID rises in that same cycle, and both flags clear.
REQ-017 Commit outcomes:
- index 0..14 in range: update the register, BRESP=2'b00.
- index 15, or out of range: no state change, BRESP=2'b10 (SLVERR), no wr_pulse.
REQ-018 With USE_WSTRB=0, all 32 bits are written regardless of WSTRB; with USE_WSTRB=1, only lanes with WSTRB[k]=1 are written, and WSTRB=0 leaves the register unchanged but still returns OKAY and still pulses wr_pulse.
REQ-019 BVALID and BRESP are held stable until BVALID&BREADY, then BVALID drops in the next cycle; AWREADY/WREADY stay low while BVALID is high.
REQ-020 Read FSM has states R_IDLE and R_DATA:
- R_IDLE: ARREADY pulses 1 cycle after ARVALID is sampled high; on handshake, go to R_DATA with RDATA/RRESP registered in the same edge.
- R_DATA: RVALID=1, RDATA/RRESP held until RVALID&RREADY, then return to R_IDLE; ARREADY=0 throughout R_DATA.
REQ-021 Read data:
- index 0..14: register value, RRESP=OKAY.
- index 15: ID_VALUE, OKAY.
- out of range: RDATA=0, RRESP=SLVERR.
REQ-022 Read/write to the same index in the same edge: the read returns the pre-write value.
REQ-023 Read and write paths are independent and may be active concurrently; the read path has no priority over the write path or vice versa.
REQ-024 Write latency: the final ready handshake to BVALID is 1 cycle; read latency: the AR handshake to RVALID is 1 cycle.

Reset
REQ-025 With rst_n=0 at a rising edge, the following clear to 0:
- all handshake outputs: AWREADY, WREADY, BVALID, ARREADY, RVALID;
- BRESP, RRESP, RDATA;
- registers 0..14, wr_pulse, aw_held, w_held;
- read FSM returns to R_IDLE.
REQ-026 Reset mid-transaction abandons it: no commit, no response; the master must reissue.
REQ-027 Outputs are valid from the first edge after rst_n rises; no extra warm-up cycles.

Verification
REQ-028 Reset, then write addr 0x0 data 0x10, bready=1 -> BRESP=00, ctrl_q[31:0]=0x10, wr_pulse[0] high for exactly 1 cycle; read 0x0 -> RDATA=0x00000010, RRESP=00.
REQ-029 Write 0x1=0x11, then 0x2=0x0000C38D, with WSTRB=0 and USE_WSTRB=0 -> reads return 0x11 and 0xC38D; register 0 is unchanged.
REQ-030 Write W before AW (WVALID 3 cycles early) to 0x3 = 0xA5A5A5A5 -> a single BVALID, OKAY, register 3 updated.
REQ-031 Write 0xF and 0x20 -> BRESP=10 each, no wr_pulse, registers unchanged; read 0xF -> ID_VALUE/OKAY, read 0x20 -> 0/10.
REQ-032 Hold BREADY low for 5 cycles -> BVALID and BRESP stay stable, AWREADY stays low despite a new AWVALID; the new write completes after BREADY is asserted.
REQ-033 Assert rst_n=0 for 1 cycle between the AW and W handshakes -> no update, no BVALID; the subsequent full write succeeds.
